// File: rtl/fifo_pkg.sv
// fifo_pkg: shared arbiter state encoding and the FIFO full limit used by the arbiter and the controller
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} arb_state_t;

    localparam int MEM_LENGTH_DEFAULT = 8;
    localparam int FIFO_MAX = 2 ** MEM_LENGTH_DEFAULT - 1;

    function automatic logic [31:0] fifo_max(input int mem_length);
        return (32'd1 << mem_length) - 32'd1;
    endfunction

    function automatic logic fifo_full(input logic [31:0] fill, input int mem_length);
        return fill == fifo_max(mem_length);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice, searching from last+1 upward with wrap
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int SW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SW-1:0]      last,
    output logic [SW-1:0]      sel,
    output logic               valid
);

    // scan farthest-first so the requester nearest after last wins
    always_comb begin
        sel = '0;
        valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NUM_REQ]) begin
                sel = SW'((int'(last) + i) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the FIFO load port, one push at a time, blocked while full
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_LENGTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    input  logic [MEM_LENGTH-1:0]         fifo_fill,
    input  logic                          fifo_accept,
    output logic                          fifo_load,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int SW = $clog2(NUM_REQ);

    arb_state_t state, state_nxt;
    logic [SW-1:0] sel, last, pick;
    logic pick_valid, full, start;

    rr_picker #(.NUM_REQ(NUM_REQ), .SW(SW)) u_picker (
        .req(req),
        .last(last),
        .sel(pick),
        .valid(pick_valid)
    );

    assign full = fifo_full(32'(fifo_fill), MEM_LENGTH);
    assign start = (state == IDLE) && pick_valid && !full;
    assign fifo_load = (state == ISSUE);
    assign busy = (state != IDLE);
    assign grant = (state == WRITE) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << sel : '0;

    // next state: load is held until the controller enters LOAD; WRITE always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ISSUE : IDLE;
            ISSUE:   state_nxt = fifo_accept ? WRITE : ISSUE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, winner latch, round-robin pointer and full-stall counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sel <= '0;
            last <= SW'(NUM_REQ - 1);
            fifo_data <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                sel <= pick;
                fifo_data <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == WRITE)
                last <= sel;
            if (state == IDLE && |req && full && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
